// File: rtl/lpddr3_phy_pkg.sv
// rtl/lpddr3_phy_pkg.sv - shared LPDDR3 PHY types and read-calibration constants
package lpddr3_phy_pkg;

  localparam int LPDDR3_DESER_WIDTH = 8;
  localparam logic [LPDDR3_DESER_WIDTH-1:0] LPDDR3_RD_CAL_PATTERN = 8'h1E;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } rx_align_state_t;

endpackage

// File: rtl/lpddr3_dq_rx_slip_align.sv
// rtl/lpddr3_dq_rx_slip_align.sv - per-DQ-bit RX word alignment via IOD bit-slip
module lpddr3_dq_rx_slip_align
  import lpddr3_phy_pkg::*;
#(
  parameter int                WIDTH         = LPDDR3_DESER_WIDTH,
  parameter logic [WIDTH-1:0]  TRAIN_PATTERN = LPDDR3_RD_CAL_PATTERN,
  parameter int                MATCH_COUNT   = 16,
  parameter int                SLIP_WAIT     = 4,
  localparam int               SLIPW         = $clog2(WIDTH) + 1
) (
  input  logic             FAB_CLK,
  input  logic             RX_SYNC_RST,
  input  logic             TRAIN_START,
  input  logic [WIDTH-1:0] RX_DATA_IN,
  output logic             RX_BIT_SLIP,
  output logic [WIDTH-1:0] RX_DATA_OUT,
  output logic             RX_DATA_VALID,
  output logic             TRAIN_DONE,
  output logic             TRAIN_FAIL,
  output logic [SLIPW-1:0] SLIP_COUNT
);

  rx_align_state_t  state, state_n;
  logic [7:0]       match_cnt, match_cnt_n;
  logic [7:0]       wait_cnt, wait_cnt_n;
  logic [SLIPW-1:0] slip_cnt, slip_cnt_n;
  logic [WIDTH-1:0] data_q;
  logic             word_match;

  assign word_match = (data_q == TRAIN_PATTERN);

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state     <= IDLE;
      match_cnt <= '0;
      wait_cnt  <= '0;
      slip_cnt  <= '0;
      data_q    <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= match_cnt_n;
      wait_cnt  <= wait_cnt_n;
      slip_cnt  <= slip_cnt_n;
      data_q    <= RX_DATA_IN;
    end
  end

  always_comb begin
    state_n     = state;
    match_cnt_n = match_cnt;
    wait_cnt_n  = wait_cnt;
    slip_cnt_n  = slip_cnt;
    case (state)
      IDLE, LOCKED, FAIL: begin
        if (TRAIN_START) begin
          state_n     = SETTLE;
          match_cnt_n = '0;
          wait_cnt_n  = '0;
          slip_cnt_n  = '0;
        end
      end
      SETTLE: begin
        // Give the IOD time to present the post-slip word before comparing.
        if (wait_cnt == 8'(SLIP_WAIT - 1)) begin
          state_n     = CHECK;
          match_cnt_n = '0;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end
      CHECK: begin
        if (word_match) begin
          if (match_cnt == 8'(MATCH_COUNT - 1)) state_n = LOCKED;
          else match_cnt_n = match_cnt + 8'd1;
        end else begin
          match_cnt_n = '0;
          // After WIDTH-1 slips every rotation has been seen once.
          if (slip_cnt < SLIPW'(WIDTH - 1)) state_n = SLIP;
          else state_n = FAIL;
        end
      end
      SLIP: begin
        if (slip_cnt < SLIPW'(WIDTH - 1)) slip_cnt_n = slip_cnt + SLIPW'(1);
        wait_cnt_n = '0;
        state_n    = SETTLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign RX_BIT_SLIP   = (state == SLIP);
  assign RX_DATA_VALID = (state == LOCKED);
  assign TRAIN_DONE    = (state == LOCKED);
  assign TRAIN_FAIL    = (state == FAIL);
  assign RX_DATA_OUT   = data_q;
  assign SLIP_COUNT    = slip_cnt;

endmodule

// File: tb/tb_lpddr3_dq_rx_slip_align.sv
// tb/tb_lpddr3_dq_rx_slip_align.sv - directed bench for lpddr3_dq_rx_slip_align
module tb_lpddr3_dq_rx_slip_align;

  logic       FAB_CLK = 1'b0;
  logic       RX_SYNC_RST = 1'b1;
  logic       TRAIN_START = 1'b0;
  logic [7:0] RX_DATA_IN = 8'h1E;
  logic       RX_BIT_SLIP;
  logic [7:0] RX_DATA_OUT;
  logic       RX_DATA_VALID;
  logic       TRAIN_DONE;
  logic       TRAIN_FAIL;
  logic [3:0] SLIP_COUNT;

  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  bit   mode_zero = 1'b0;
  bit   corrupt = 1'b0;
  logic [2:0] slip_hist = 3'b000;
  int   slips = 0;
  int   cyc = 0;
  int   last_slip = -1;
  bit   prev_slip = 1'b0;

  lpddr3_dq_rx_slip_align dut (
    .FAB_CLK       (FAB_CLK),
    .RX_SYNC_RST   (RX_SYNC_RST),
    .TRAIN_START   (TRAIN_START),
    .RX_DATA_IN    (RX_DATA_IN),
    .RX_BIT_SLIP   (RX_BIT_SLIP),
    .RX_DATA_OUT   (RX_DATA_OUT),
    .RX_DATA_VALID (RX_DATA_VALID),
    .TRAIN_DONE    (TRAIN_DONE),
    .TRAIN_FAIL    (TRAIN_FAIL),
    .SLIP_COUNT    (SLIP_COUNT)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // One fabric cycle; also acts as the IOD model (slip visible 3 cycles later).
  task automatic tick();
    @(posedge FAB_CLK);
    #1;
    cyc++;
    if (RX_BIT_SLIP) begin
      slips++;
      chk("slip_back_to_back", 32'(prev_slip), 32'd0);
      if (last_slip >= 0) chk("slip_gap", 32'(cyc - last_slip), 32'd6);
      last_slip = cyc;
    end
    prev_slip = RX_BIT_SLIP;
    if (slip_hist[2]) k = (k + 7) % 8;
    slip_hist = {slip_hist[1:0], RX_BIT_SLIP};
    RX_DATA_IN = corrupt ? 8'h1F : (mode_zero ? 8'h00 : rotl(8'h1E, k));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_pulse();
    slips = 0;
    last_slip = -1;
    TRAIN_START = 1'b1;
    tick();
    TRAIN_START = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int bound);
    int n;
    n = 0;
    while (!(TRAIN_DONE || TRAIN_FAIL) && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(TRAIN_DONE | TRAIN_FAIL), 32'd1);
  endtask

  initial begin
    ticks(3);
    chk("rst_done", 32'(TRAIN_DONE), 32'd0);
    chk("rst_fail", 32'(TRAIN_FAIL), 32'd0);
    chk("rst_valid", 32'(RX_DATA_VALID), 32'd0);
    chk("rst_slip", 32'(RX_BIT_SLIP), 32'd0);
    chk("rst_slip_count", 32'(SLIP_COUNT), 32'd0);
    chk("rst_data_out", 32'(RX_DATA_OUT), 32'd0);
    RX_SYNC_RST = 1'b0;
    ticks(3);
    chk("idle_data_out", 32'(RX_DATA_OUT), 32'h1E);

    // Aligned: lock exactly 21 cycles after the start cycle.
    start_pulse();
    ticks(19);
    chk("k0_done_early", 32'(TRAIN_DONE), 32'd0);
    tick();
    chk("k0_done", 32'(TRAIN_DONE), 32'd1);
    chk("k0_valid", 32'(RX_DATA_VALID), 32'd1);
    chk("k0_slip_count", 32'(SLIP_COUNT), 32'd0);
    chk("k0_slips", 32'(slips), 32'd0);
    chk("k0_data_out", 32'(RX_DATA_OUT), 32'h1E);

    // Restart from LOCKED.
    start_pulse();
    chk("relock_done_drop", 32'(TRAIN_DONE), 32'd0);
    chk("relock_valid_drop", 32'(RX_DATA_VALID), 32'd0);
    chk("relock_slip_count", 32'(SLIP_COUNT), 32'd0);
    ticks(19);
    chk("relock_done_early", 32'(TRAIN_DONE), 32'd0);
    tick();
    chk("relock_done", 32'(TRAIN_DONE), 32'd1);

    // Offset k=3: three slips then lock.
    k = 3;
    tick();
    start_pulse();
    wait_end("k3_end", 300);
    chk("k3_done", 32'(TRAIN_DONE), 32'd1);
    chk("k3_fail", 32'(TRAIN_FAIL), 32'd0);
    chk("k3_slips", 32'(slips), 32'd3);
    chk("k3_slip_count", 32'(SLIP_COUNT), 32'd3);
    chk("k3_data_out", 32'(RX_DATA_OUT), 32'h1E);
    chk("k3_valid", 32'(RX_DATA_VALID), 32'd1);

    // Constant zero input: full rotation then FAIL.
    mode_zero = 1'b1;
    start_pulse();
    wait_end("zero_end", 300);
    chk("zero_fail", 32'(TRAIN_FAIL), 32'd1);
    chk("zero_done", 32'(TRAIN_DONE), 32'd0);
    chk("zero_slips", 32'(slips), 32'd7);
    chk("zero_slip_count", 32'(SLIP_COUNT), 32'd7);
    ticks(10);
    chk("zero_fail_sticky", 32'(TRAIN_FAIL), 32'd1);
    chk("zero_no_more_slips", 32'(slips), 32'd7);

    // Glitch at match 10: one slip, then k=7 exhausts the rotation budget.
    mode_zero = 1'b0;
    k = 0;
    tick();
    start_pulse();
    ticks(12);
    corrupt = 1'b1;
    tick();
    corrupt = 1'b0;
    tick();
    chk("glitch_no_slip_yet", 32'(RX_BIT_SLIP), 32'd0);
    tick();
    chk("glitch_slip", 32'(RX_BIT_SLIP), 32'd1);
    tick();
    chk("glitch_slip_count", 32'(SLIP_COUNT), 32'd1);
    chk("glitch_done", 32'(TRAIN_DONE), 32'd0);
    wait_end("glitch_end", 300);
    chk("glitch_fail", 32'(TRAIN_FAIL), 32'd1);
    chk("glitch_final_slip_count", 32'(SLIP_COUNT), 32'd7);

    // Reset in CHECK with match_cnt=8, TRAIN_START in the same cycle.
    k = 0;
    tick();
    start_pulse();
    ticks(12);
    RX_SYNC_RST = 1'b1;
    TRAIN_START = 1'b1;
    tick();
    RX_SYNC_RST = 1'b0;
    TRAIN_START = 1'b0;
    chk("mid_rst_done", 32'(TRAIN_DONE), 32'd0);
    chk("mid_rst_fail", 32'(TRAIN_FAIL), 32'd0);
    chk("mid_rst_valid", 32'(RX_DATA_VALID), 32'd0);
    chk("mid_rst_slip", 32'(RX_BIT_SLIP), 32'd0);
    chk("mid_rst_data_out", 32'(RX_DATA_OUT), 32'd0);
    ticks(30);
    chk("mid_rst_start_ignored", 32'(TRAIN_DONE), 32'd0);
    chk("mid_rst_slips", 32'(slips), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
